// File: rtl/spi_flash_arbiter_if.sv
// Signal bundle between the CPU memory unit / SPI flash reader (master side) and the arbiter (slave side).
// Requests are levels that stay high with a stable address until the matching ack pulse; ack is a single-cycle
// pulse whose data is valid in that cycle. spi_start is a level held until spi_recv_done is sampled.
interface spi_flash_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [31:0]       fetch_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic              flush;
    logic              spi_init_done;
    logic              spi_start;
    logic [ADDR_W-1:0] spi_addr;
    logic [31:0]       spi_instr;
    logic              spi_recv_done;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        dbg_state;
    logic              dbg_buf_valid;

    modport master (
        output fetch_req, fetch_addr, mem_req, mem_addr, flush,
               spi_init_done, spi_instr, spi_recv_done,
        input  fetch_ack, fetch_data, mem_ack, mem_data, spi_start, spi_addr,
               busy, timeout_err, dbg_state, dbg_buf_valid
    );

    modport slave (
        input  fetch_req, fetch_addr, mem_req, mem_addr, flush,
               spi_init_done, spi_instr, spi_recv_done,
        output fetch_ack, fetch_data, mem_ack, mem_data, spi_start, spi_addr,
               busy, timeout_err, dbg_state, dbg_buf_valid
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash word reader between fetch and data ports,
// with a one-entry last-word buffer and a WAIT-state watchdog. All outputs are registered.
module spi_flash_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    spi_flash_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_HIT   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];

    state_t            r_state, w_state_nx;
    logic              r_last_mem, w_last_mem_nx;
    logic              r_grant_mem, w_grant_mem_nx;
    logic [ADDR_W-1:0] r_spi_addr, w_spi_addr_nx;
    logic              r_spi_start, w_spi_start_nx;
    logic              r_fetch_ack, w_fetch_ack_nx;
    logic              r_mem_ack, w_mem_ack_nx;
    logic [31:0]       r_fetch_data, w_fetch_data_nx;
    logic [31:0]       r_mem_data, w_mem_data_nx;
    logic              r_busy, w_busy_nx;
    logic              r_timeout_err, w_timeout_err_nx;
    logic [ADDR_W-1:0] r_buf_addr, w_buf_addr_nx;
    logic [31:0]       r_buf_data, w_buf_data_nx;
    logic              r_buf_valid, w_buf_valid_nx;
    logic [7:0]        r_wd_cnt, w_wd_cnt_nx;

    logic              w_req_mem;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_hit;
    logic [7:0]        w_wd_inc;
    logic              w_resp_valid;
    logic [31:0]       w_resp_data;

    always_comb begin
        w_state_nx       = r_state;
        w_last_mem_nx    = r_last_mem;
        w_grant_mem_nx   = r_grant_mem;
        w_spi_addr_nx    = r_spi_addr;
        w_spi_start_nx   = r_spi_start;
        w_fetch_ack_nx   = 1'b0;
        w_mem_ack_nx     = 1'b0;
        w_fetch_data_nx  = r_fetch_data;
        w_mem_data_nx    = r_mem_data;
        w_timeout_err_nx = 1'b0;
        w_buf_addr_nx    = r_buf_addr;
        w_buf_data_nx    = r_buf_data;
        w_buf_valid_nx   = r_buf_valid & ~bus.flush;
        w_wd_cnt_nx      = r_wd_cnt;
        w_resp_valid     = 1'b0;
        w_resp_data      = 32'h0;
        // On a tie the port that did not win last time is granted.
        w_req_mem  = bus.mem_req & (~bus.fetch_req | ~r_last_mem);
        w_req_addr = w_req_mem ? bus.mem_addr : bus.fetch_addr;
        w_hit      = r_buf_valid & (r_buf_addr == w_req_addr) & ~bus.flush;
        w_wd_inc   = r_wd_cnt + 8'd1;

        case (r_state)
            S_INIT: begin
                if (bus.spi_init_done) w_state_nx = S_READY;
            end
            S_READY: begin
                if (bus.fetch_req | bus.mem_req) begin
                    w_grant_mem_nx = w_req_mem;
                    w_last_mem_nx  = w_req_mem;
                    w_spi_addr_nx  = w_req_addr;
                    if (w_hit) begin
                        w_state_nx   = S_HIT;
                        w_resp_valid = 1'b1;
                        w_resp_data  = r_buf_data;
                    end else begin
                        w_state_nx     = S_WAIT;
                        w_spi_start_nx = 1'b1;
                        w_wd_cnt_nx    = 8'd0;
                    end
                end
            end
            S_HIT: begin
                w_state_nx = S_READY;
            end
            S_WAIT: begin
                // A word arriving on the expiry edge still counts as success.
                if (bus.spi_recv_done) begin
                    w_state_nx     = S_READY;
                    w_spi_start_nx = 1'b0;
                    w_resp_valid   = 1'b1;
                    w_resp_data    = bus.spi_instr;
                    w_buf_addr_nx  = r_spi_addr;
                    w_buf_data_nx  = bus.spi_instr;
                    w_buf_valid_nx = ~bus.flush;
                end else if (w_wd_inc == TO_LIMIT) begin
                    w_state_nx       = S_READY;
                    w_spi_start_nx   = 1'b0;
                    w_timeout_err_nx = 1'b1;
                    w_resp_valid     = 1'b1;
                    w_resp_data      = 32'h0;
                end else begin
                    w_wd_cnt_nx = w_wd_inc;
                end
            end
            default: w_state_nx = S_INIT;
        endcase

        if (w_resp_valid) begin
            if (w_grant_mem_nx) begin
                w_mem_ack_nx  = 1'b1;
                w_mem_data_nx = w_resp_data;
            end else begin
                w_fetch_ack_nx  = 1'b1;
                w_fetch_data_nx = w_resp_data;
            end
        end

        w_busy_nx = (w_state_nx != S_READY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_INIT;
            r_last_mem    <= 1'b1;
            r_grant_mem   <= 1'b0;
            r_spi_addr    <= '0;
            r_spi_start   <= 1'b0;
            r_fetch_ack   <= 1'b0;
            r_mem_ack     <= 1'b0;
            r_fetch_data  <= 32'h0;
            r_mem_data    <= 32'h0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_data    <= 32'h0;
            r_buf_valid   <= 1'b0;
            r_wd_cnt      <= 8'd0;
        end else begin
            r_state       <= w_state_nx;
            r_last_mem    <= w_last_mem_nx;
            r_grant_mem   <= w_grant_mem_nx;
            r_spi_addr    <= w_spi_addr_nx;
            r_spi_start   <= w_spi_start_nx;
            r_fetch_ack   <= w_fetch_ack_nx;
            r_mem_ack     <= w_mem_ack_nx;
            r_fetch_data  <= w_fetch_data_nx;
            r_mem_data    <= w_mem_data_nx;
            r_busy        <= w_busy_nx;
            r_timeout_err <= w_timeout_err_nx;
            r_buf_addr    <= w_buf_addr_nx;
            r_buf_data    <= w_buf_data_nx;
            r_buf_valid   <= w_buf_valid_nx;
            r_wd_cnt      <= w_wd_cnt_nx;
        end
    end

    assign bus.fetch_ack     = r_fetch_ack;
    assign bus.fetch_data    = r_fetch_data;
    assign bus.mem_ack       = r_mem_ack;
    assign bus.mem_data      = r_mem_data;
    assign bus.spi_start     = r_spi_start;
    assign bus.spi_addr      = r_spi_addr;
    assign bus.busy          = r_busy;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.dbg_state     = r_state;
    assign bus.dbg_buf_valid = r_buf_valid;
endmodule
